// File: rtl/uart_rx_if.sv
// Receive-side bus between uart_rx and its consumer (UART bus interface or RX FIFO).
// The receiver drives through 'master'; the consumer reads through 'slave'.
interface uart_rx_if;
  logic [7:0] RxD_data;
  logic       data_ready;
  logic       frame_error;
  logic       busy;

  modport master (
    output RxD_data,
    output data_ready,
    output frame_error,
    output busy
  );

  modport slave (
    input RxD_data,
    input data_ready,
    input frame_error,
    input busy
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver sampling RxD with a 16x oversampling tick.
// Delivers framed bytes and framing errors as one-cycle strobes.
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     uart_tick_16x,
  input  logic     RxD,
  uart_rx_if.master rx_bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_CNT  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] ONE_CNT  = CW'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_s;
  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [2:0]             bit_idx_r, bit_idx_s;
  logic [7:0]             shift_r, shift_s;
  logic [7:0]             data_r, data_s;
  logic                   ready_r, ready_s;
  logic                   ferr_r, ferr_s;
  logic                   busy_r;

  // Metastability synchronizer; resets to the idle-high line level
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_r <= '1;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], RxD};
    end
  end

  assign rx_s = sync_r[SYNC_STAGES-1];

  // Receiver state and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      ready_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      data_r    <= data_s;
      ready_r   <= ready_s;
      ferr_r    <= ferr_s;
      busy_r    <= (state_s != ST_IDLE);
    end
  end

  // Next-state and strobe decode; everything advances only on a tick
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    data_s    = data_r;
    ready_s   = 1'b0;
    ferr_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (uart_tick_16x && !rx_s) begin
          state_s = ST_START;
          cnt_s   = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (uart_tick_16x && (cnt_r == MID_CNT)) begin
          cnt_s = '0;
          if (!rx_s) begin
            state_s   = ST_DATA;
            bit_idx_s = 3'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (uart_tick_16x) begin
          cnt_s = cnt_r + ONE_CNT;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_DATA: begin
        if (uart_tick_16x && (cnt_r == LAST_CNT)) begin
          shift_s   = {rx_s, shift_r[7:1]};
          cnt_s     = '0;
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else if (uart_tick_16x) begin
          cnt_s = cnt_r + ONE_CNT;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_STOP: begin
        // Leaving at mid stop bit lets a zero-gap start edge be caught
        if (uart_tick_16x && (cnt_r == LAST_CNT)) begin
          cnt_s = '0;
          if (rx_s) begin
            data_s  = shift_r;
            ready_s = 1'b1;
            state_s = ST_IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = ST_BREAK;
          end
        end else if (uart_tick_16x) begin
          cnt_s = cnt_r + ONE_CNT;
        end else begin
          cnt_s = cnt_r;
        end
      end
      ST_BREAK: begin
        if (uart_tick_16x && rx_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BREAK;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  assign rx_bus.RxD_data    = data_r;
  assign rx_bus.data_ready  = ready_r;
  assign rx_bus.frame_error = ferr_r;
  assign rx_bus.busy        = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a timed serial sender drives RxD at arbitrary baud offsets and
// an event-queue model of 8N1 framing predicts the strobes and held byte.
`timescale 1ps/1ps
module tb_uart_rx;
  localparam int OS     = 16;
  localparam int CLK_PS = 10000;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic uart_tick_16x = 1'b0;
  logic RxD = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.OVERSAMPLE(OS), .SYNC_STAGES(2)) dut (
    .clock        (clock),
    .reset        (reset),
    .uart_tick_16x(uart_tick_16x),
    .RxD          (RxD),
    .rx_bus       (bus)
  );

  always #(CLK_PS / 2) clock = ~clock;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } ev_t;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         pct;
    int         gap_bits;
    logic       exp_ferr;
    logic [7:0] exp_data;
    bit         check_after;
  } vec_t;

  int         tick_div = 2;
  int         checks = 0;
  int         failures = 0;
  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [7:0] last_good = 8'h00;
  bit         prev_strobe = 1'b0;
  vec_t       vecs[10];

  function automatic int bit_ps(input int pct);
    return (OS * tick_div * CLK_PS * (100 + pct)) / 100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Tick generator: one-clock pulse every tick_div clocks
  initial begin
    int tcnt = 0;
    forever begin
      @(negedge clock);
      if (tcnt >= tick_div - 1) begin
        uart_tick_16x = 1'b1;
        tcnt = 0;
      end else begin
        uart_tick_16x = 1'b0;
        tcnt++;
      end
    end
  end

  // Strobe monitor: records every event and checks exclusivity and width
  initial begin
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_strobe = 1'b0;
      end else if (bus.data_ready || bus.frame_error) begin
        chk("strobe_excl", 32'(bus.data_ready && bus.frame_error), 32'd0);
        chk("strobe_width", 32'(prev_strobe), 32'd0);
        obs_q.push_back({bus.frame_error, bus.RxD_data});
        prev_strobe = 1'b1;
      end else begin
        prev_strobe = 1'b0;
      end
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input int pct);
    int b;
    b = bit_ps(pct);
    RxD = 1'b0;
    #b;
    for (int i = 0; i < 8; i++) begin
      RxD = d[i];
      #b;
    end
    RxD = stop;
    #b;
  endtask

  task automatic expect_byte(input logic [7:0] d);
    exp_q.push_back({1'b0, d});
    last_good = d;
  endtask

  task automatic check_events(input string name);
    RxD = 1'b1;
    #(2 * bit_ps(0));
    chk({name, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      chk({name, "_event"}, 32'(obs_q[i]), 32'(exp_q[i]));
    end
    chk({name, "_held"}, 32'(bus.RxD_data), 32'(last_good));
    chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] d;
    int         pct;
    int         gap;
    int         b;

    vecs[0] = '{8'h55, 1'b1,  0, 1, 1'b0, 8'h55, 1'b1};
    vecs[1] = '{8'h00, 1'b1,  0, 0, 1'b0, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1,  0, 0, 1'b0, 8'hFF, 1'b0};
    vecs[3] = '{8'h81, 1'b1,  0, 0, 1'b0, 8'h81, 1'b1};
    vecs[4] = '{8'h00, 1'b1,  3, 0, 1'b0, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 1'b1,  3, 0, 1'b0, 8'hFF, 1'b0};
    vecs[6] = '{8'h81, 1'b1,  3, 0, 1'b0, 8'h81, 1'b1};
    vecs[7] = '{8'h00, 1'b1, -3, 0, 1'b0, 8'h00, 1'b0};
    vecs[8] = '{8'hFF, 1'b1, -3, 0, 1'b0, 8'hFF, 1'b0};
    vecs[9] = '{8'h81, 1'b1, -3, 0, 1'b0, 8'h81, 1'b1};

    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_data", 32'(bus.RxD_data), 32'h00);
    chk("rst_ready", 32'(bus.data_ready), 32'd0);
    chk("rst_ferr", 32'(bus.frame_error), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    #(2 * bit_ps(0));

    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].pct);
      if (vecs[i].exp_ferr) begin
        exp_q.push_back({1'b1, last_good});
      end else begin
        expect_byte(vecs[i].exp_data);
      end
      RxD = 1'b1;
      #(vecs[i].gap_bits * bit_ps(0));
      if (vecs[i].check_after) begin
        check_events("table");
      end
    end

    // Short low glitch must be rejected at mid start bit
    @(negedge clock);
    RxD = 1'b0;
    repeat (3 * tick_div) @(negedge clock);
    chk("glitch_busy", 32'(bus.busy), 32'd1);
    repeat (tick_div) @(negedge clock);
    RxD = 1'b1;
    check_events("glitch");

    // Framing error followed by a long break, then a normal frame
    send_frame(8'hA3, 1'b0, 0);
    exp_q.push_back({1'b1, last_good});
    #(20 * bit_ps(0));
    check_events("break");
    send_frame(8'h3C, 1'b1, 0);
    expect_byte(8'h3C);
    check_events("after_break");

    // Random bytes, baud offsets and idle gaps
    for (int n = 0; n < 20; n++) begin
      d   = 8'($urandom_range(255));
      pct = int'($urandom_range(6)) - 3;
      gap = int'($urandom_range(2));
      send_frame(d, 1'b1, pct);
      expect_byte(d);
      RxD = 1'b1;
      #(gap * bit_ps(0));
    end
    check_events("random");

    // Reset during bit 4 discards the partial byte
    b = bit_ps(0);
    d = 8'hC6;
    RxD = 1'b0;
    #b;
    for (int i = 0; i < 4; i++) begin
      RxD = d[i];
      #b;
    end
    RxD = d[4];
    #(b / 2);
    @(negedge clock);
    reset = 1'b1;
    RxD = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("mid_rst_data", 32'(bus.RxD_data), 32'h00);
    chk("mid_rst_ready", 32'(bus.data_ready), 32'd0);
    chk("mid_rst_ferr", 32'(bus.frame_error), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    last_good = 8'h00;
    check_events("reset_abort");
    send_frame(8'h7E, 1'b1, 0);
    expect_byte(8'h7E);
    check_events("after_reset");

    // Loopback-style stream of all byte values, back to back
    tick_div = 1;
    #(2 * bit_ps(0));
    for (int i = 0; i < 256; i++) begin
      send_frame(8'(i), 1'b1, 0);
      expect_byte(8'(i));
    end
    check_events("loopback");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 serial receiver; the receive counterpart to the XUM SoC UART transmitter.
- Samples the asynchronous RxD pin with a 16x-oversampling tick from the shared baud generator.
- Validates the start bit, recovers 8 data bits LSB first, and checks the stop bit.
- Presents each byte with a one-cycle strobe to the UART bus interface or RX FIFO; framing errors are reported on a separate strobe.

Parameters:
- OVERSAMPLE, 16: uart_tick_16x pulses per bit period. Must be even and ≥ 4.
- SYNC_STAGES, 2: flip-flop stages in the RxD metastability synchronizer. Must be ≥ 2.

Ports:
- clock, input, 1: system clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high.
- uart_tick_16x, input, 1: one-clock pulse, OVERSAMPLE times per bit period.
- RxD, input, 1: asynchronous serial line; idle high.
- RxD_data, output, 8: last correctly framed byte; held until the next good byte.
- data_ready, output, 1: one-clock pulse when RxD_data is updated.
- frame_error, output, 1: one-clock pulse when the stop bit samples low.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Synchronizer:
  - RxD passes through SYNC_STAGES flops, all reset and initialised to 1.
  - rx_s is the synchronizer output; all decisions use rx_s only.
- Sample counter: cnt, width clog2(OVERSAMPLE). Advances only on uart_tick_16x.
- Bit index: bit_idx, 3 bits.
- Shift register: 8 bits, right shift; the new bit enters at [7].
- States: IDLE, START, DATA, STOP, BREAK. busy = (state != IDLE).
- IDLE:
  - On a tick with rx_s == 0: go to START, cnt <= 0.
- START:
  - On a tick with cnt == OVERSAMPLE/2-1 (mid start bit):
    - rx_s == 0: go to DATA, cnt <= 0, bit_idx <= 0.
    - rx_s == 1: glitch rejected; go to IDLE with no output strobe.
  - Otherwise, on a tick: cnt++.
- DATA:
  - On a tick with cnt == OVERSAMPLE-1: shift rx_s in, cnt <= 0, bit_idx++.
  - After the sample taken at bit_idx == 7: go to STOP.
  - Otherwise, on a tick: cnt++.
- STOP:
  - On a tick with cnt == OVERSAMPLE-1 (mid stop bit):
    - rx_s == 1: RxD_data <= shift register, data_ready = 1 on the next cycle, go to IDLE.
    - rx_s == 0: frame_error = 1 on the next cycle, RxD_data unchanged, go to BREAK.
  - Otherwise, on a tick: cnt++.
- BREAK:
  - Waits for rx_s == 1, sampled on a tick, then goes to IDLE.
  - This prevents a held-low line (break) from producing repeated phantom frames.
- Back-to-back frames: returning to IDLE at mid stop bit allows a start edge immediately after the stop bit to be caught. Zero idle gap is supported.
- Latency:
  - data_ready asserts exactly one clock after the tick that samples mid stop bit.
  - From the RxD falling edge, this is about 9.5 bit periods plus SYNC_STAGES+1 clocks.
- Strobes: data_ready and frame_error are registered, never high simultaneously, and never high for more than one cycle.
- Reset values:
  - state = IDLE, cnt = 0, bit_idx = 0, shift register = 0x00.
  - RxD_data = 0x00, data_ready = 0, frame_error = 0, busy = 0.
  - Synchronizer flops = 1.
- Reset mid-frame: the partial byte is discarded and no strobe is issued.
  - If RxD is still low after reset, the mid-frame low bits can be taken as a start bit. A false frame or frame_error may follow; software must tolerate one.
- Ticks absent: the FSM holds state indefinitely; no timeout.
- Baud tolerance: receiver must decode correctly with sender baud offset within ±3% of nominal.

Test Plan:
- Send 0x55, 8N1, exact baud, OVERSAMPLE=16:
  - one data_ready pulse with RxD_data == 0x55;
  - frame_error never asserts;
  - busy low afterwards.
- RxD low pulse of 4 ticks, then high:
  - START rejects it and returns to IDLE;
  - no data_ready, no frame_error; RxD_data keeps its prior value.
- Send 0xA3 with stop bit = 0, then hold RxD low for 20 bit times, then release high:
  - exactly one frame_error pulse;
  - RxD_data unchanged;
  - no further strobes until the line is high, then a normal 0x3C frame is received.
- Send 0x00, 0xFF, 0x81 back-to-back with no idle bits:
  - three data_ready pulses in order with the correct bytes;
  - repeat with sender baud at +3% and −3%; all bytes are still correct.
- Assert reset for one cycle during bit 4 of a frame, with the line then held high:
  - all outputs return to reset values;
  - no strobe for the aborted byte;
  - the next full frame, 0x7E, is received correctly.
- Loopback from the team's UART transmitter at the same baud, 256 sequential bytes 0x00–0xFF:
  - all received in order with no frame_error.
